character_ctl: RTL

//  Character motion controller, directly downstream of the game state machine.
//  - Consumes the jump_left / jump_right command pulses and the jump_fail event.
//  - Animates the character on a per-frame ballistic arc, or a straight fall.
//  - Returns character_landed to the state machine, which uses it to leave the FLY and FALL states.
//  - Drives xpos/ypos to the character renderer.

---
 rtl/character_ctl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/character_ctl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// character_ctl : per-frame ballistic jump / straight fall motion controller
// Revision      : 1.0
// ----------------------------------------------------------------------------
module character_ctl #(
   parameter int X_START  = 400,
   parameter int Y_GROUND = 500,
   parameter int Y_FLOOR  = 599,
   parameter int X_MIN    = 0,
   parameter int X_MAX    = 736,
   parameter int X_SPEED  = 2,
   parameter int JUMP_V0  = 12,
   parameter int GRAVITY  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        restart,
   input  logic        jump_left,
   input  logic        jump_right,
   input  logic        jump_fail,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        busy,
   output logic        character_landed
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FLY  = 2'd1,
      ST_FALL = 2'd2,
      ST_DOWN = 2'd3
   } state_t;

   localparam logic [11:0]        c_x_start  = 12'(X_START);
   localparam logic [11:0]        c_y_ground = 12'(Y_GROUND);
   localparam logic [11:0]        c_y_floor  = 12'(Y_FLOOR);
   localparam logic [11:0]        c_x_min    = 12'(X_MIN);
   localparam logic [11:0]        c_x_max    = 12'(X_MAX);
   localparam logic signed [12:0] c_x_speed  = 13'(X_SPEED);
   localparam logic signed [7:0]  c_jump_v0  = 8'(JUMP_V0);
   localparam logic signed [7:0]  c_gravity  = 8'(GRAVITY);

   state_t             state_q, state_d;
   logic [11:0]        xpos_q, xpos_d;
   logic [11:0]        ypos_q, ypos_d;
   logic [11:0]        y_base_q, y_base_d;
   logic signed [7:0]  vy_q, vy_d;
   logic               dir_q, dir_d;
   logic               busy_q, busy_d;
   logic               landed_q, landed_d;

   logic signed [12:0] y_sum;
   logic signed [12:0] x_step;

   always_comb begin
      state_d  = state_q;
      xpos_d   = xpos_q;
      ypos_d   = ypos_q;
      y_base_d = y_base_q;
      vy_d     = vy_q;
      dir_d    = dir_q;
      landed_d = 1'b0;

      // 13-bit signed intermediates keep overshoot above y=0 / past the clamps visible
      y_sum  = $signed({1'b0, ypos_q}) + $signed({{5{vy_q[7]}}, vy_q});
      x_step = dir_q ? ($signed({1'b0, xpos_q}) + c_x_speed)
                     : ($signed({1'b0, xpos_q}) - c_x_speed);

      if (restart) begin
         state_d = ST_IDLE;
         xpos_d  = c_x_start;
         ypos_d  = c_y_ground;
         vy_d    = 8'sd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (jump_fail) begin
                  state_d = ST_FALL;
                  vy_d    = 8'sd0;
               end else if (jump_left ^ jump_right) begin
                  state_d  = ST_FLY;
                  vy_d     = -c_jump_v0;
                  y_base_d = ypos_q;
                  dir_d    = jump_right;
               end
            end
            ST_FLY: begin
               if (frame_tick) begin
                  vy_d = vy_q + c_gravity;
                  if (x_step < $signed({1'b0, c_x_min})) begin
                     xpos_d = c_x_min;
                  end else if (x_step > $signed({1'b0, c_x_max})) begin
                     xpos_d = c_x_max;
                  end else begin
                     xpos_d = x_step[11:0];
                  end
                  if (y_sum >= $signed({1'b0, y_base_q})) begin
                     ypos_d   = y_base_q;
                     vy_d     = 8'sd0;
                     landed_d = 1'b1;
                     state_d  = ST_IDLE;
                  end else if (y_sum < 13'sd0) begin
                     ypos_d = 12'd0;
                  end else begin
                     ypos_d = y_sum[11:0];
                  end
               end
            end
            ST_FALL: begin
               if (frame_tick) begin
                  vy_d = vy_q + c_gravity;
                  if (y_sum >= $signed({1'b0, c_y_floor})) begin
                     ypos_d   = c_y_floor;
                     vy_d     = 8'sd0;
                     landed_d = 1'b1;
                     state_d  = ST_DOWN;
                  end else begin
                     ypos_d = y_sum[11:0];
                  end
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d == ST_FLY) || (state_d == ST_FALL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         xpos_q   <= c_x_start;
         ypos_q   <= c_y_ground;
         y_base_q <= c_y_ground;
         vy_q     <= 8'sd0;
         dir_q    <= 1'b0;
         busy_q   <= 1'b0;
         landed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         xpos_q   <= xpos_d;
         ypos_q   <= ypos_d;
         y_base_q <= y_base_d;
         vy_q     <= vy_d;
         dir_q    <= dir_d;
         busy_q   <= busy_d;
         landed_q <= landed_d;
      end
   end

   assign xpos             = xpos_q;
   assign ypos             = ypos_q;
   assign busy             = busy_q;
   assign character_landed = landed_q;

endmodule
`default_nettype wire
